fifo_write_ctrl: RTL and testbench

- Parametrised write-side controller for the asynchronous FIFO.
- Sits in the write clock domain. Owns the binary and Gray write pointers and the RAM write address.
- Synchronises the read-domain Gray pointer internally and produces registered full, almost_full and fill-level outputs.
- Adds flush, sticky overflow detection and a saturating dropped-write counter.

---
 rtl/fifo_write_ctrl_if.sv | 31 +++
 rtl/fifo_write_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_write_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_ctrl_if.sv
// Write-side bundle between the producer, the async FIFO write controller and the RAM.
// The controller takes the slave view; the producer/testbench drives through master.
interface fifo_write_ctrl_if #(
   parameter int PTR_WIDTH  = 4,
   parameter int DROP_WIDTH = 16
);
   logic                  flush;
   logic                  wr_enable;
   logic [PTR_WIDTH:0]    rd_ptr_gray;
   logic                  overflow_clr;
   logic                  fifo_wr_enable;
   logic [PTR_WIDTH-1:0]  wr_addr;
   logic [PTR_WIDTH:0]    write_ptr_gray;
   logic                  full;
   logic                  almost_full;
   logic [PTR_WIDTH:0]    wr_level;
   logic                  overflow;
   logic [DROP_WIDTH-1:0] drop_count;

   modport master (
      output flush, wr_enable, rd_ptr_gray, overflow_clr,
      input  fifo_wr_enable, wr_addr, write_ptr_gray, full, almost_full,
             wr_level, overflow, drop_count
   );

   modport slave (
      input  flush, wr_enable, rd_ptr_gray, overflow_clr,
      output fifo_wr_enable, wr_addr, write_ptr_gray, full, almost_full,
             wr_level, overflow, drop_count
   );
endinterface

// File: rtl/fifo_write_ctrl.sv
// Write-domain controller of the async FIFO: binary/Gray write pointers, read-pointer
// synchroniser, registered full/almost_full/level, flush, sticky overflow and drop counter.
module fifo_write_ctrl #(
   parameter int PTR_WIDTH   = 4,
   parameter int AF_THRESH   = 12,
   parameter int SYNC_STAGES = 2,
   parameter int DROP_WIDTH  = 16
) (
   input  logic            w_clk,
   input  logic            wreset,
   fifo_write_ctrl_if.slave bus
);
   localparam int PW = PTR_WIDTH;
   localparam logic [PW:0] AF_LVL = (PW+1)'(AF_THRESH);

   logic [PW:0]           sync_q [SYNC_STAGES];
   logic [PW:0]           rq;
   logic [PW:0]           rbin;

   logic [PW:0]           wbin_q, wbin_d;
   logic [PW:0]           wgray_q, wgray_d;
   logic [PW:0]           level_q, level_d;
   logic                  full_q, full_d;
   logic                  af_q, af_d;
   logic                  ovf_q, ovf_d;
   logic [DROP_WIDTH-1:0] drop_q, drop_d;

   logic                  wr_fire;
   logic                  set_ovf;
   logic [PW:0]           wbin_next;
   logic [PW:0]           diff;

   always_ff @(posedge w_clk or posedge wreset) begin
      if (wreset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= bus.rd_ptr_gray;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign rq = sync_q[SYNC_STAGES-1];

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   generate
      for (genvar gi = 0; gi <= PW; gi++) begin : g_rbin
         assign rbin[gi] = ^rq[PW:gi];
      end
   endgenerate

   always_comb begin
      // Gated by wreset so nothing reaches the RAM while reset is held.
      wr_fire   = bus.wr_enable & ~full_q & ~bus.flush & ~wreset;
      set_ovf   = bus.wr_enable & full_q & ~bus.flush;
      wbin_next = wbin_q + {{PW{1'b0}}, wr_fire};

      wbin_d  = bus.flush ? '0 : wbin_next;
      wgray_d = wbin_d ^ (wbin_d >> 1);
      diff    = wbin_d - rbin;
      level_d = bus.flush ? '0 : diff;
      full_d  = (wgray_d == {~rq[PW:PW-1], rq[PW-2:0]});
      af_d    = (diff >= AF_LVL);

      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (bus.flush) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end else begin
         if (set_ovf)                ovf_d = 1'b1;
         else if (bus.overflow_clr)  ovf_d = 1'b0;
         if (set_ovf && (drop_q != '1)) drop_d = drop_q + DROP_WIDTH'(1);
      end
   end

   always_ff @(posedge w_clk or posedge wreset) begin
      if (wreset) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         level_q <= level_d;
         full_q  <= full_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.fifo_wr_enable = wr_fire;
   assign bus.wr_addr        = wbin_q[PW-1:0];
   assign bus.write_ptr_gray = wgray_q;
   assign bus.full           = full_q;
   assign bus.almost_full    = af_q;
   assign bus.wr_level       = level_q;
   assign bus.overflow       = ovf_q;
   assign bus.drop_count     = drop_q;
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed self-checking bench for fifo_write_ctrl with PTR_WIDTH=4, AF_THRESH=12, SYNC_STAGES=2.
module tb_fifo_write_ctrl;
   logic w_clk = 1'b0;
   logic wreset;
   int   n_cmp = 0;
   int   n_err = 0;

   fifo_write_ctrl_if #(.PTR_WIDTH(4), .DROP_WIDTH(16)) bus ();

   fifo_write_ctrl #(
      .PTR_WIDTH(4), .AF_THRESH(12), .SYNC_STAGES(2), .DROP_WIDTH(16)
   ) dut (
      .w_clk  (w_clk),
      .wreset (wreset),
      .bus    (bus)
   );

   always #5 w_clk = ~w_clk;

   function automatic logic [4:0] g(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic test_reset();
      wreset = 1'b1;
      bus.flush = 1'b0; bus.wr_enable = 1'b0; bus.rd_ptr_gray = '0; bus.overflow_clr = 1'b0;
      #2;
      n_cmp++;
      if ({bus.fifo_wr_enable, bus.wr_addr, bus.write_ptr_gray, bus.full, bus.almost_full,
           bus.wr_level, bus.overflow, bus.drop_count} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got gray=%b level=%0d full=%b drop=%0d, want all 0",
                  bus.write_ptr_gray, bus.wr_level, bus.full, bus.drop_count);
      end
      tick();
      wreset = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         bus.wr_enable = 1'b1;
         #1;
         n_cmp++;
         if (bus.fifo_wr_enable !== 1'b1 || bus.wr_addr !== 4'(i)) begin
            n_err++;
            $display("FAIL fill_accept[%0d]: got we=%b addr=%0d, want we=1 addr=%0d",
                     i, bus.fifo_wr_enable, bus.wr_addr, i);
         end
         tick();
         $display("fill write %0d: addr=%0d gray=%b level=%0d af=%b full=%b",
                  i, i, bus.write_ptr_gray, bus.wr_level, bus.almost_full, bus.full);
         n_cmp++;
         if (bus.almost_full !== (i >= 11) || bus.full !== (i == 15) || bus.wr_level !== 5'(i + 1)) begin
            n_err++;
            $display("FAIL fill_flags[%0d]: got af=%b full=%b level=%0d, want af=%b full=%b level=%0d",
                     i, bus.almost_full, bus.full, bus.wr_level, (i >= 11), (i == 15), i + 1);
         end
      end
      n_cmp++;
      if (bus.write_ptr_gray !== 5'b11000) begin
         n_err++;
         $display("FAIL fill_gray: got %b, want 11000", bus.write_ptr_gray);
      end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 3; k++) begin
         bus.wr_enable = 1'b1;
         #1;
         n_cmp++;
         if (bus.fifo_wr_enable !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_reject[%0d]: got we=%b, want 0", k, bus.fifo_wr_enable);
         end
         tick();
         n_cmp++;
         if (bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag[%0d]: got %b, want 1", k, bus.overflow);
         end
      end
      bus.wr_enable = 1'b0;
      n_cmp++;
      if (bus.drop_count !== 16'd3 || bus.write_ptr_gray !== 5'b11000 || bus.wr_addr !== 4'd0
          || bus.wr_level !== 5'd16) begin
         n_err++;
         $display("FAIL ovf_state: got drop=%0d gray=%b addr=%0d level=%0d, want 3 11000 0 16",
                  bus.drop_count, bus.write_ptr_gray, bus.wr_addr, bus.wr_level);
      end
   endtask

   task automatic test_read_release();
      bus.wr_enable   = 1'b0;
      bus.rd_ptr_gray = 5'b00001;
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_cmp++;
         if (bus.full !== (c < 3)) begin
            n_err++;
            $display("FAIL release_full[%0d]: got %b, want %b", c, bus.full, (c < 3));
         end
      end
      n_cmp++;
      if (bus.wr_level !== 5'd15) begin
         n_err++;
         $display("FAIL release_level: got %0d, want 15", bus.wr_level);
      end
      bus.wr_enable = 1'b1;
      #1;
      n_cmp++;
      if (bus.fifo_wr_enable !== 1'b1 || bus.wr_addr !== 4'd0) begin
         n_err++;
         $display("FAIL release_accept: got we=%b addr=%0d, want we=1 addr=0",
                  bus.fifo_wr_enable, bus.wr_addr);
      end
      tick();
      bus.wr_enable = 1'b0;
      n_cmp++;
      if (bus.full !== 1'b1 || bus.write_ptr_gray !== 5'b11001 || bus.wr_level !== 5'd16) begin
         n_err++;
         $display("FAIL refull: got full=%b gray=%b level=%0d, want 1 11001 16",
                  bus.full, bus.write_ptr_gray, bus.wr_level);
      end
   endtask

   task automatic test_ovf_clr();
      bus.wr_enable    = 1'b1;
      bus.overflow_clr = 1'b1;
      tick();
      n_cmp++;
      if (bus.overflow !== 1'b1 || bus.drop_count !== 16'd4) begin
         n_err++;
         $display("FAIL clr_set_wins: got ovf=%b drop=%0d, want 1 4", bus.overflow, bus.drop_count);
      end
      bus.wr_enable = 1'b0;
      tick();
      bus.overflow_clr = 1'b0;
      n_cmp++;
      if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd4) begin
         n_err++;
         $display("FAIL clr_alone: got ovf=%b drop=%0d, want 0 4", bus.overflow, bus.drop_count);
      end
   endtask

   task automatic test_flush();
      bus.rd_ptr_gray = 5'b01100;
      repeat (3) tick();
      n_cmp++;
      if (bus.wr_level !== 5'd9 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
         n_err++;
         $display("FAIL preflush_level: got level=%0d full=%b af=%b, want 9 0 0",
                  bus.wr_level, bus.full, bus.almost_full);
      end
      bus.flush = 1'b1; bus.wr_enable = 1'b1; bus.rd_ptr_gray = 5'b00000;
      #1;
      n_cmp++;
      if (bus.fifo_wr_enable !== 1'b0) begin
         n_err++;
         $display("FAIL flush_gate: got we=%b, want 0", bus.fifo_wr_enable);
      end
      tick();
      bus.flush = 1'b0; bus.wr_enable = 1'b0;
      n_cmp++;
      if (bus.write_ptr_gray !== 5'd0 || bus.wr_level !== 5'd0 || bus.drop_count !== 16'd0
          || bus.overflow !== 1'b0 || bus.wr_addr !== 4'd0) begin
         n_err++;
         $display("FAIL flush_clear: got gray=%b level=%0d drop=%0d ovf=%b addr=%0d, want all 0",
                  bus.write_ptr_gray, bus.wr_level, bus.drop_count, bus.overflow, bus.wr_addr);
      end
      repeat (3) tick();
      n_cmp++;
      if (bus.wr_level !== 5'd0 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
         n_err++;
         $display("FAIL flush_settle: got level=%0d full=%b af=%b, want 0 0 0",
                  bus.wr_level, bus.full, bus.almost_full);
      end
   endtask

   task automatic test_wrap();
      logic [4:0] prev;
      logic [4:0] exp_lvl;
      for (int i = 0; i < 40; i++) begin
         bus.wr_enable   = 1'b1;
         bus.rd_ptr_gray = (i >= 2) ? g(5'(i - 2)) : 5'd0;
         #1;
         n_cmp++;
         if (bus.fifo_wr_enable !== 1'b1 || bus.wr_addr !== 4'(i)) begin
            n_err++;
            $display("FAIL wrap_accept[%0d]: got we=%b addr=%0d, want we=1 addr=%0d",
                     i, bus.fifo_wr_enable, bus.wr_addr, i % 16);
         end
         prev = bus.write_ptr_gray;
         tick();
         exp_lvl = 5'(i + 1) - ((i >= 4) ? 5'(i - 4) : 5'd0);
         $display("wrap write %0d: gray=%b level=%0d full=%b", i, bus.write_ptr_gray,
                  bus.wr_level, bus.full);
         n_cmp++;
         if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.write_ptr_gray !== g(5'(i + 1))
             || $countones(bus.write_ptr_gray ^ prev) != 1 || bus.wr_level !== exp_lvl) begin
            n_err++;
            $display("FAIL wrap[%0d]: got full=%b af=%b gray=%b prev=%b level=%0d, want 0 0 %b one-bit %0d",
                     i, bus.full, bus.almost_full, bus.write_ptr_gray, prev, bus.wr_level,
                     g(5'(i + 1)), exp_lvl);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.wr_enable = 1'b1;
      #3;
      wreset = 1'b1;
      #1;
      n_cmp++;
      if ({bus.fifo_wr_enable, bus.wr_addr, bus.write_ptr_gray, bus.full, bus.almost_full,
           bus.wr_level, bus.overflow, bus.drop_count} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got we=%b addr=%0d gray=%b level=%0d, want all 0",
                  bus.fifo_wr_enable, bus.wr_addr, bus.write_ptr_gray, bus.wr_level);
      end
      tick();
      n_cmp++;
      if (bus.write_ptr_gray !== 5'd0 || bus.wr_level !== 5'd0 || bus.fifo_wr_enable !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: got gray=%b level=%0d we=%b, want 0 0 0",
                  bus.write_ptr_gray, bus.wr_level, bus.fifo_wr_enable);
      end
      wreset = 1'b0;
      bus.wr_enable = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_read_release();
      test_ovf_clr();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
